// File: rtl/cep_stream_decoder.sv
// Receive-side CEP stream decoder: assembles link beats into packets, checks framing,
// splits header/payload words and buffers decoded packets. Optional counters: CEP_STREAM_DECODER_STATS_EN.
module cep_stream_decoder #(
    parameter int unsigned CEP_WIDTH      = 512,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned LINK_WIDTH     = 128,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned REQ_HDR_WORDS  = 3,
    parameter int unsigned RESP_HDR_WORDS = 1,
    parameter int unsigned IS_REQ_BIT     = CEP_WIDTH - 1,
    localparam int unsigned NW     = CEP_WIDTH / WORD_WIDTH,
    localparam int unsigned DW     = NW - RESP_HDR_WORDS,
    localparam int unsigned HDR_W  = REQ_HDR_WORDS * WORD_WIDTH,
    localparam int unsigned DATA_W = DW * WORD_WIDTH,
    localparam int unsigned CNT_W  = $clog2(DW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [LINK_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_rdy,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic                  out_is_request,
    output logic [HDR_W-1:0]      out_header,
    output logic [DATA_W-1:0]     out_data,
    output logic [CNT_W-1:0]      out_data_words,
`ifdef CEP_STREAM_DECODER_STATS_EN
    output logic [31:0]           req_cnt,
    output logic [31:0]           resp_cnt,
    output logic [15:0]           err_cnt,
`endif
    output logic                  frame_err
);

    localparam int unsigned BEATS = CEP_WIDTH / LINK_WIDTH;
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DROP    = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [BCW-1:0]        beat_cnt;
    logic [BCW-1:0]        beat_cnt_next;
    logic [LINK_WIDTH-1:0] beat_buf [BEATS];
    logic [CEP_WIDTH-1:0]  pkt_c;
    logic                  accept_c;
    logic                  last_beat_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  err_c;

    logic                  dec_is_req_c;
    int unsigned           hdr_words_c;
    logic [HDR_W-1:0]      dec_hdr_c;
    logic [DATA_W-1:0]     dec_data_c;
    logic [CNT_W-1:0]      dec_words_c;

    logic [FCW-1:0]        fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  fifo_is_req [FIFO_DEPTH];
    logic [HDR_W-1:0]      fifo_hdr    [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data   [FIFO_DEPTH];
    logic [CNT_W-1:0]      fifo_words  [FIFO_DEPTH];

    // Backpressure depends only on registered state, never on out_rdy.
    assign in_rdy      = (state == ST_DROP) || (fifo_count < FCW'(FIFO_DEPTH));
    assign accept_c    = in_val && in_rdy;
    assign last_beat_c = (beat_cnt == BCW'(BEATS - 1));
    assign out_val     = (fifo_count != '0);
    assign pop_c       = out_val && out_rdy;

    // Framing state machine: next state, beat counter, push and error strobes.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        push_c        = 1'b0;
        err_c         = 1'b0;
        if (accept_c) begin
            if (state == ST_DROP) begin
                if (in_last) begin
                    state_next = ST_COLLECT;
                end
            end else if (!last_beat_c) begin
                if (in_last) begin
                    err_c         = 1'b1;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt + BCW'(1);
                end
            end else begin
                beat_cnt_next = '0;
                if (in_last) begin
                    push_c = 1'b1;
                end else begin
                    err_c      = 1'b1;
                    state_next = ST_DROP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state     <= ST_COLLECT;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            beat_cnt  <= beat_cnt_next;
            frame_err <= err_c;
        end
    end

    // Beat slots hold data only; validity is tracked by beat_cnt.
    always_ff @(posedge clk) begin : beat_store
        if (accept_c && (state == ST_COLLECT)) begin
            beat_buf[beat_cnt] <= in_data;
        end
    end

    // Full packet as seen on the final beat: stored slots plus the live beat.
    always_comb begin
        pkt_c = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            pkt_c[i*LINK_WIDTH +: LINK_WIDTH] = (BCW'(i) == beat_cnt) ? in_data : beat_buf[i];
        end
    end

    // Split into low-aligned header and payload; shifting fills unused payload words with zero.
    always_comb begin
        dec_is_req_c = pkt_c[IS_REQ_BIT];
        hdr_words_c  = dec_is_req_c ? REQ_HDR_WORDS : RESP_HDR_WORDS;
        dec_hdr_c    = '0;
        for (int unsigned h = 0; h < REQ_HDR_WORDS; h++) begin
            if (h < hdr_words_c) begin
                dec_hdr_c[h*WORD_WIDTH +: WORD_WIDTH] = pkt_c[h*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        dec_data_c  = DATA_W'(pkt_c >> (hdr_words_c * WORD_WIDTH));
        dec_words_c = CNT_W'(NW - hdr_words_c);
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin : fifo_ctrl
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Entries are cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin : fifo_store
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_is_req[i] <= 1'b0;
                fifo_hdr[i]    <= '0;
                fifo_data[i]   <= '0;
                fifo_words[i]  <= '0;
            end
        end else if (push_c) begin
            fifo_is_req[wr_ptr] <= dec_is_req_c;
            fifo_hdr[wr_ptr]    <= dec_hdr_c;
            fifo_data[wr_ptr]   <= dec_data_c;
            fifo_words[wr_ptr]  <= dec_words_c;
        end
    end

    assign out_is_request = fifo_is_req[rd_ptr];
    assign out_header     = fifo_hdr[rd_ptr];
    assign out_data       = fifo_data[rd_ptr];
    assign out_data_words = fifo_words[rd_ptr];

`ifdef CEP_STREAM_DECODER_STATS_EN
    // Packet counters wrap; the error counter saturates.
    always_ff @(posedge clk) begin : stats
        if (rst) begin
            req_cnt  <= '0;
            resp_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push_c && dec_is_req_c) begin
                req_cnt <= req_cnt + 32'd1;
            end
            if (push_c && !dec_is_req_c) begin
                resp_cnt <= resp_cnt + 32'd1;
            end
            if (err_c && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cep_stream_decoder.sv
// Testbench for cep_stream_decoder: directed framing/backpressure cases plus random traffic
// checked every cycle against a queue-based packet model.
module tb_cep_stream_decoder;

    localparam int unsigned CEP_WIDTH      = 512;
    localparam int unsigned WORD_WIDTH     = 64;
    localparam int unsigned LINK_WIDTH     = 128;
    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned REQ_HDR_WORDS  = 3;
    localparam int unsigned RESP_HDR_WORDS = 1;
    localparam int unsigned IS_REQ_BIT     = CEP_WIDTH - 1;
    localparam int unsigned BEATS          = CEP_WIDTH / LINK_WIDTH;
    localparam int unsigned NW             = CEP_WIDTH / WORD_WIDTH;
    localparam int unsigned DW             = NW - RESP_HDR_WORDS;
    localparam int unsigned HDR_W          = REQ_HDR_WORDS * WORD_WIDTH;
    localparam int unsigned DATA_W         = DW * WORD_WIDTH;
    localparam int unsigned CNT_W          = $clog2(DW + 1);

    typedef logic [CEP_WIDTH-1:0] wide_t;

    typedef struct {
        bit               is_req;
        logic [HDR_W-1:0] hdr;
        logic [DATA_W-1:0] data;
        int               words;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  in_val;
    logic [LINK_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_rdy;
    logic                  out_val;
    logic                  out_rdy;
    logic                  out_is_request;
    logic [HDR_W-1:0]      out_header;
    logic [DATA_W-1:0]     out_data;
    logic [CNT_W-1:0]      out_data_words;
    logic                  frame_err;
`ifdef CEP_STREAM_DECODER_STATS_EN
    logic [31:0]           req_cnt;
    logic [31:0]           resp_cnt;
    logic [15:0]           err_cnt;
`endif

    cep_stream_decoder #(
        .CEP_WIDTH      (CEP_WIDTH),
        .WORD_WIDTH     (WORD_WIDTH),
        .LINK_WIDTH     (LINK_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .REQ_HDR_WORDS  (REQ_HDR_WORDS),
        .RESP_HDR_WORDS (RESP_HDR_WORDS),
        .IS_REQ_BIT     (IS_REQ_BIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_val         (in_val),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_rdy         (in_rdy),
        .out_val        (out_val),
        .out_rdy        (out_rdy),
        .out_is_request (out_is_request),
        .out_header     (out_header),
        .out_data       (out_data),
        .out_data_words (out_data_words),
`ifdef CEP_STREAM_DECODER_STATS_EN
        .req_cnt        (req_cnt),
        .resp_cnt       (resp_cnt),
        .err_cnt        (err_cnt),
`endif
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit rdy_mode = 1'b0;

    // Reference model state
    logic [LINK_WIDTH-1:0] beat_q [$];
    exp_t                  exp_q  [$];
    bit                    m_drop = 1'b0;
    bit                    m_err  = 1'b0;
    int                    m_req  = 0;
    int                    m_resp = 0;
    int                    m_errs = 0;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t decode(input wide_t pkt);
        exp_t e;
        logic [WORD_WIDTH-1:0] w [NW];
        int hw;
        for (int i = 0; i < int'(NW); i++) w[i] = pkt[i*WORD_WIDTH +: WORD_WIDTH];
        e.is_req = pkt[IS_REQ_BIT];
        hw = e.is_req ? int'(REQ_HDR_WORDS) : int'(RESP_HDR_WORDS);
        e.hdr  = '0;
        e.data = '0;
        for (int h = 0; h < hw; h++) e.hdr[h*WORD_WIDTH +: WORD_WIDTH] = w[h];
        for (int d = 0; d + hw < int'(NW); d++) e.data[d*WORD_WIDTH +: WORD_WIDTH] = w[d + hw];
        e.words = int'(NW) - hw;
        return e;
    endfunction

    // Model: acts on the same handshakes the DUT sees, using only its own occupancy.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                beat_q.delete();
                exp_q.delete();
                m_drop = 1'b0;
                m_err  = 1'b0;
                m_req  = 0;
                m_resp = 0;
                m_errs = 0;
            end else begin
                bit    pop;
                bit    acc;
                bit    err;
                wide_t pkt;
                exp_t  e;
                pop = (exp_q.size() > 0) && out_rdy;
                acc = in_val && (m_drop || (exp_q.size() < int'(FIFO_DEPTH)));
                err = 1'b0;
                if (pop) void'(exp_q.pop_front());
                if (acc) begin
                    if (m_drop) begin
                        if (in_last) m_drop = 1'b0;
                    end else begin
                        beat_q.push_back(in_data);
                        if (beat_q.size() == int'(BEATS)) begin
                            if (in_last) begin
                                for (int b = 0; b < int'(BEATS); b++) pkt[b*LINK_WIDTH +: LINK_WIDTH] = beat_q[b];
                                e = decode(pkt);
                                exp_q.push_back(e);
                                if (e.is_req) m_req++; else m_resp++;
                            end else begin
                                err    = 1'b1;
                                m_drop = 1'b1;
                            end
                            beat_q.delete();
                        end else if (in_last) begin
                            err = 1'b1;
                            beat_q.delete();
                        end
                    end
                end
                m_err = err;
                if (err && m_errs < 16'hFFFF) m_errs++;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_val", wide_t'(out_val), wide_t'(exp_q.size() > 0));
                check("in_rdy", wide_t'(in_rdy), wide_t'(m_drop || (exp_q.size() < int'(FIFO_DEPTH))));
                check("frame_err", wide_t'(frame_err), wide_t'(m_err));
                if (exp_q.size() > 0) begin
                    check("out_is_request", wide_t'(out_is_request), wide_t'(exp_q[0].is_req));
                    check("out_header", wide_t'(out_header), wide_t'(exp_q[0].hdr));
                    check("out_data", wide_t'(out_data), wide_t'(exp_q[0].data));
                    check("out_data_words", wide_t'(out_data_words), wide_t'(exp_q[0].words));
                end
`ifdef CEP_STREAM_DECODER_STATS_EN
                check("req_cnt", wide_t'(req_cnt), wide_t'(m_req));
                check("resp_cnt", wide_t'(resp_cnt), wide_t'(m_resp));
                check("err_cnt", wide_t'(err_cnt), wide_t'(m_errs));
`endif
            end
        end
    end

    // Random consumer readiness.
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_mode) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_beat(input logic [LINK_WIDTH-1:0] d, input logic last);
        int waited;
        waited  = 0;
        in_val  = 1'b1;
        in_data = d;
        in_last = last;
        while (!in_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_rdy) begin
            tests++;
            fails++;
            $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1 within 200 cycles");
        end else begin
            @(negedge clk);
        end
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_pkt(input wide_t p);
        for (int b = 0; b < int'(BEATS); b++) send_beat(p[b*LINK_WIDTH +: LINK_WIDTH], (b == int'(BEATS) - 1));
    endtask

    function automatic wide_t rand_pkt(input bit is_req);
        wide_t p;
        for (int i = 0; i < int'(CEP_WIDTH / 32); i++) p[i*32 +: 32] = $urandom;
        p[IS_REQ_BIT] = is_req;
        return p;
    endfunction

    function automatic wide_t seq_pkt(input bit is_req);
        wide_t p;
        for (int i = 0; i < int'(NW); i++) p[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(i);
        p[IS_REQ_BIT] = is_req;
        return p;
    endfunction

    task automatic pop_one();
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited  = 0;
        out_rdy = 1'b1;
        while (exp_q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check(name, wide_t'(out_val), wide_t'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HDR_W-1:0]  lit_hdr;
        logic [DATA_W-1:0] lit_data;
        int k;
        int n;
        rst = 1'b1; in_val = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_out_val", wide_t'(out_val), wide_t'(0));
        check("rst_in_rdy", wide_t'(in_rdy), wide_t'(1));
        check("rst_frame_err", wide_t'(frame_err), wide_t'(0));
        check("rst_out_header", wide_t'(out_header), wide_t'(0));
        check("rst_out_data", wide_t'(out_data), wide_t'(0));
        check("rst_out_words", wide_t'(out_data_words), wide_t'(0));

        // Request with sequential words; IS_REQ rides in the top bit of word 7
        send_pkt(seq_pkt(1'b1));
        lit_hdr  = {64'h2, 64'h1, 64'h0};
        lit_data = {64'h0, 64'h0, 64'h8000_0000_0000_0007, 64'h6, 64'h5, 64'h4, 64'h3};
        check("req_latency_val", wide_t'(out_val), wide_t'(1));
        check("req_is_request", wide_t'(out_is_request), wide_t'(1));
        check("req_header", wide_t'(out_header), wide_t'(lit_hdr));
        check("req_data", wide_t'(out_data), wide_t'(lit_data));
        check("req_words", wide_t'(out_data_words), wide_t'(5));
        check("model_req_header", wide_t'(exp_q[0].hdr), wide_t'(lit_hdr));
        pop_one();

        // Response with sequential words
        send_pkt(seq_pkt(1'b0));
        lit_hdr  = {64'h0, 64'h0, 64'h0};
        lit_data = {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1};
        check("resp_is_request", wide_t'(out_is_request), wide_t'(0));
        check("resp_header", wide_t'(out_header), wide_t'(lit_hdr));
        check("resp_data", wide_t'(out_data), wide_t'(lit_data));
        check("resp_words", wide_t'(out_data_words), wide_t'(7));
        check("model_resp_data", wide_t'(exp_q[0].data), wide_t'(lit_data));
        pop_one();

        // Backpressure: two buffered, third stalls on beat 0
        fork
            begin
                send_pkt(rand_pkt(1'b1));
                send_pkt(rand_pkt(1'b0));
                send_pkt(rand_pkt(1'b1));
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_in_rdy", wide_t'(in_rdy), wide_t'(0));
                check("bp_out_val", wide_t'(out_val), wide_t'(1));
                check("bp_buffered", wide_t'(exp_q.size()), wide_t'(2));
                out_rdy = 1'b1;
            end
        join
        drain("bp_drained");
        check("bp_in_rdy_after", wide_t'(in_rdy), wide_t'(1));

        // Early end on beat 1
        send_beat(LINK_WIDTH'(128'h11), 1'b0);
        send_beat(LINK_WIDTH'(128'h22), 1'b1);
        check("early_err_pulse", wide_t'(frame_err), wide_t'(1));
        @(negedge clk);
        check("early_err_clear", wide_t'(frame_err), wide_t'(0));
        send_pkt(rand_pkt(1'b1));
        drain("early_followup");

        // Late end: four beats without last, two more with last on the second
        for (int b = 0; b < int'(BEATS); b++) send_beat(LINK_WIDTH'(b), 1'b0);
        check("late_err_pulse", wide_t'(frame_err), wide_t'(1));
        send_beat(LINK_WIDTH'(128'h55), 1'b0);
        check("late_single_pulse", wide_t'(frame_err), wide_t'(0));
        send_beat(LINK_WIDTH'(128'h66), 1'b1);
        send_pkt(rand_pkt(1'b0));
        drain("late_followup");

        // Reset mid-packet
        for (int b = 0; b < 3; b++) send_beat(LINK_WIDTH'(b + 9), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_val", wide_t'(out_val), wide_t'(0));
        send_pkt(rand_pkt(1'b1));
        check("midrst_pkt_val", wide_t'(out_val), wide_t'(1));
        drain("midrst_followup");

        // Random traffic with random consumer stalls
        out_rdy  = 1'b0;
        rdy_mode = 1'b1;
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 99);
            if (k < 65) begin
                send_pkt(rand_pkt(1'($urandom_range(0, 1))));
            end else if (k < 77) begin
                n = $urandom_range(1, BEATS - 1);
                for (int b = 0; b < n; b++) send_beat(LINK_WIDTH'($urandom), (b == n - 1));
            end else if (k < 89) begin
                for (int b = 0; b < int'(BEATS); b++) send_beat(LINK_WIDTH'($urandom), 1'b0);
                n = $urandom_range(1, 3);
                for (int b = 0; b < n; b++) send_beat(LINK_WIDTH'($urandom), (b == n - 1));
            end else if (k < 96) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end else begin
                n = $urandom_range(0, BEATS - 1);
                for (int b = 0; b < n; b++) send_beat(LINK_WIDTH'($urandom), 1'b0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        rdy_mode = 1'b0;
        @(negedge clk);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cep_stream_decoder.md
Name: cep_stream_decoder

Overview:
- Receive-side CEP packet deserializer and decoder for the inter-chip link. Collects LINK_WIDTH-bit beats from the link PHY into a full CEP packet.
- Checks framing, splits the packet into header and payload words by request/response type, and buffers decoded packets in a small FIFO with a valid/ready output.
- Sits between the chip-bridge receive path and the CEP-to-NoC encoders.
- Generalises the combinational CEP decoder: parametrised link width, packet width and buffer depth, plus sequential assembly, backpressure and error detection.

Parameters:
- CEP_WIDTH, 512, full CEP packet width in bits (`CEP_DATA_WIDTH).
- WORD_WIDTH, 64, CEP word width (`CEP_WORD_WIDTH).
- LINK_WIDTH, 128, beat width; CEP_WIDTH must be an integer multiple of it.
- FIFO_DEPTH, 2, decoded-packet buffer entries, >=1.
- REQ_HDR_WORDS, 3, header words in a request packet.
- RESP_HDR_WORDS, 1, header words in a response packet.
- Derived: BEATS=CEP_WIDTH/LINK_WIDTH; NW=CEP_WIDTH/WORD_WIDTH; DW=NW-RESP_HDR_WORDS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_val  in  1  beat valid.
- in_data  in  LINK_WIDTH  beat payload; beat i occupies packet bits [i*LINK_WIDTH +: LINK_WIDTH].
- in_last  in  1  marks the final beat of a packet.
- in_rdy  out  1  beat accepted when in_val&&in_rdy.
- out_val  out  1  decoded packet available.
- out_rdy  in  1  consumer accepts; pop on out_val&&out_rdy.
- out_is_request  out  1  packet bit `CEP_IS_REQ.
- out_header  out  REQ_HDR_WORDS*WORD_WIDTH  header words, low-aligned, unused words zero.
- out_data  out  DW*WORD_WIDTH  payload words, low-aligned, unused words zero.
- out_data_words  out  $clog2(DW+1)  valid payload word count.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: all outputs 0; FIFO empty; beat_cnt=0; state=COLLECT. Reset mid-packet discards the partial packet; the next accepted beat is beat 0.
- in_rdy = (fifo_count < FIFO_DEPTH) in COLLECT; 1 in DROP. No combinational path from out_rdy to in_rdy.
- State COLLECT, accepted beat:
  - Store the beat at slot beat_cnt.
  - beat_cnt<BEATS-1 and !in_last: beat_cnt++.
  - beat_cnt<BEATS-1 and in_last: early end. Discard, frame_err=1 next cycle, beat_cnt=0, stay COLLECT.
  - beat_cnt==BEATS-1 and in_last: packet complete. Decode, push to FIFO, beat_cnt=0.
  - beat_cnt==BEATS-1 and !in_last: late end. Discard, frame_err=1 next cycle, beat_cnt=0, go to DROP.
- State DROP: accept and discard beats. A beat with in_last returns the block to COLLECT; that beat is also discarded.
- BEATS==1: every beat is final; in_last=0 is a late-end error.
- Decode at push, registered into the FIFO entry:
  - Request: header = words 0..REQ_HDR_WORDS-1; data = words REQ_HDR_WORDS..NW-1; out_data_words = NW-REQ_HDR_WORDS.
  - Response: header = words 0..RESP_HDR_WORDS-1; data = words RESP_HDR_WORDS..NW-1; out_data_words = DW.
  - Unused header/data words are zero.
- Latency: final beat accepted in cycle N gives out_val=1 in cycle N+1 when the FIFO was empty.
- FIFO ordering and flow:
  - FIFO is in-order. Outputs show the head entry and are held stable while out_val&&!out_rdy.
  - Simultaneous push and pop when full is impossible, since in_rdy=0 when full.
  - Simultaneous push and pop at any other level leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_err is a pulse, not sticky. Back-to-back errors give consecutive pulses.

Optional Feature:
- Macro: CEP_STREAM_DECODER_STATS_EN.
- Defined: adds outputs req_cnt[31:0], resp_cnt[31:0] and err_cnt[15:0].
  - req_cnt / resp_cnt count pushed packets of each type.
  - err_cnt counts frame_err pulses and saturates at 16'hFFFF.
  - All three reset to 0; req_cnt and resp_cnt wrap.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults; 4 beats with words 0..7 = 64'h0..64'h7, IS_REQ=1, in_last on beat 3 -> out_val one cycle later; header={2,1,0}; data words 0..4 = 3..7, words 5..6 = 0; out_data_words=5.
- Same packet with IS_REQ=0 -> header word0=0, words1..2=0; data words 0..6 = 1..7; out_data_words=7.
- Hold out_rdy=0 and send 3 packets -> 2 buffered, in_rdy=0 on 3rd packet beat 0; raise out_rdy -> 3 packets emerge in order, none lost.
- in_last on beat 1 -> frame_err pulse, no push; next valid 4-beat packet decodes correctly.
- 4 beats without in_last, then 2 more beats with in_last on the 2nd -> one frame_err, all 6 beats dropped; following packet OK.
- Assert rst after beat 2 -> nothing pushed; a full packet afterwards decodes correctly. With CEP_STREAM_DECODER_STATS_EN, the counters match the packets pushed and frame_err pulses.
